nx_stream_distributor: RTL
==========================

Name: nx_stream_distributor

Overview:
- Transmit-side counterpart to the per-link receive skid buffers of the node mesh.
- Accepts one node_message_t stream from a node's egress and steers each message to one of five outbound streams: north, east, south, west, or local bypass.
- Steering is dimension-ordered (column first, then row) against the node's own position.
- Each outbound stream has an independent 2-entry buffer, so backpressure on one direction does not stall the others except when the head message targets that direction.

Parameters:
- None. Widths come from NXConstants (node_message_t, ID_WIDTH).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_node_row  input  ID_WIDTH  this node's row, static after reset
- i_node_column  input  ID_WIDTH  this node's column, static after reset
- i_inbound_data  input  node_message_t  message to route
- i_inbound_valid  input  1  inbound valid
- o_inbound_ready  output  1  inbound ready
- o_outbound_data[4]  output  node_message_t  per-direction data, indexed by direction_t (NORTH=0, EAST=1, SOUTH=2, WEST=3)
- o_outbound_valid[4]  output  1 each  per-direction valid
- i_outbound_ready[4]  input  1 each  per-direction ready
- o_bypass_data  output  node_message_t  local-delivery data
- o_bypass_valid  output  1  local-delivery valid
- i_bypass_ready  input  1  local-delivery ready

Behaviour:
- Routing is decoded combinationally from i_inbound_data.header.row and header.column, compared unsigned against the node position:
  - column > own: EAST.
  - column < own: WEST.
  - column equal, row > own: SOUTH.
  - column equal, row < own: NORTH.
  - both equal: bypass.
- Handshake:
  - Inbound transfer occurs when i_inbound_valid && o_inbound_ready.
  - o_inbound_ready = the decoded target buffer is not full. It depends combinationally on inbound data (the decode) but never on any outbound ready.
  - A valid message must not be dropped or duplicated.
  - Data is held stable by the upstream while valid && !ready; that is the upstream's obligation and is not checked here.
- Buffers:
  - Five identical 2-entry FIFOs, one per output.
  - Latency is 1 cycle: a message accepted in cycle N appears at its output in cycle N+1 if that buffer was empty.
  - Output valid = buffer not empty. Output data = head entry, registered with no combinational path from inbound.
  - Outbound transfer occurs when valid && ready; the head pops that cycle.
- Throughput:
  - One message per cycle per direction is sustained when the downstream ready is held high.
  - A simultaneous push and pop on a full buffer is NOT allowed: ready reflects registered fullness only. This keeps ready timing registered-plus-decode.
- Ordering:
  - Order is preserved within each direction.
  - No ordering guarantee between directions.
- Head-of-line: when the target buffer is full, o_inbound_ready is low and all later messages wait, even those bound for free directions. This is intended.
- Reset:
  - All five buffers go empty immediately (asynchronous).
  - All o_*_valid = 0, all o_*_data = 0, and o_inbound_ready = 1 during and after reset.
  - Messages in flight are discarded.
- Boundary conditions:
  - A row or column at 0 or the maximum ID value routes normally; no wrap-around is applied.
  - Both FIFO pointers are 1 bit and wrap modulo 2.
  - Count is 0..2. Push when full or pop when empty is unreachable and is asserted against in simulation.

Decomposition:
- NXConstants gains direction_t (NORTH, EAST, SOUTH, WEST).
- node_message_t and ID_WIDTH already live there.
- Sub-module nx_stream_buffer2 holds one 2-entry node_message_t FIFO with push/pop, empty/full and registered head. It is instantiated five times.
- The routing decode is a package function, nx_route_direction, that returns a direction or a bypass flag.

Test Plan:
- Node (2,3), push targets (2,5), (2,1), (4,3), (0,3), (2,3), all readies high -> each appears once on EAST, WEST, SOUTH, NORTH, bypass respectively, exactly 1 cycle after its acceptance.
- Node (2,3), 10 back-to-back messages to (7,7) with EAST ready high -> 10 outputs on consecutive cycles, in order; o_inbound_ready stays high.
- EAST ready low, push 3 messages to (2,5) -> the first two are accepted and the third stalls with o_inbound_ready=0. Raise EAST ready -> all three drain in order, with no loss or duplication.
- EAST blocked and full, head targets (2,5), next message targets (0,3) -> NORTH receives nothing until EAST drains (head-of-line check).
- Assert i_rst mid-stream with 2 entries buffered in SOUTH -> all valids drop and data reads 0 in the same cycle, without waiting for a clock edge. After release, o_inbound_ready=1 and no stale messages emerge.
- Node (0,0), target (0,0) with bypass ready low for 5 cycles -> bypass valid held with data stable; the message is delivered once when ready rises.

Source files
------------

// File: rtl/nx_stream_distributor_pkg.sv
// Shared node-mesh constants and types: message layout, ID width,
// outbound direction encoding and the dimension-ordered routing decode.
package NXConstants;

    localparam int ID_WIDTH        = 4;
    localparam int COMMAND_WIDTH   = 2;
    localparam int PAYLOAD_WIDTH   = 22;

    // Four mesh directions plus the local bypass stream.
    localparam int DIRECTION_COUNT = 4;
    localparam int STREAM_COUNT    = 5;
    localparam int BYPASS_INDEX    = 4;

    typedef struct packed {
        logic [ID_WIDTH-1:0]      row;
        logic [ID_WIDTH-1:0]      column;
        logic [COMMAND_WIDTH-1:0] command;
    } node_header_t;

    typedef struct packed {
        node_header_t             header;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } node_message_t;

    typedef enum logic [1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } direction_t;

    // Result of the routing decode: either a mesh direction or local delivery.
    typedef struct packed {
        logic       bypass;
        direction_t direction;
    } route_t;

    // Dimension-ordered routing: resolve the column first, then the row.
    // Comparisons are unsigned and never wrap, so IDs at 0 or the maximum
    // value route exactly like any other.
    function automatic route_t nx_route_direction(
        input logic [ID_WIDTH-1:0] target_row,
        input logic [ID_WIDTH-1:0] target_column,
        input logic [ID_WIDTH-1:0] own_row,
        input logic [ID_WIDTH-1:0] own_column
    );
        route_t route;
        route.bypass    = 1'b0;
        route.direction = NORTH;
        if (target_column > own_column) begin
            route.direction = EAST;
        end else if (target_column < own_column) begin
            route.direction = WEST;
        end else if (target_row > own_row) begin
            route.direction = SOUTH;
        end else if (target_row < own_row) begin
            route.direction = NORTH;
        end else begin
            route.bypass = 1'b1;
        end
        return route;
    endfunction

    // Flatten a route onto the 0..4 stream index (directions 0..3, bypass 4).
    function automatic logic [2:0] nx_stream_index(input route_t route);
        logic [2:0] index;
        if (route.bypass) begin
            index = 3'(BYPASS_INDEX);
        end else begin
            index = {1'b0, route.direction};
        end
        return index;
    endfunction

endpackage

// File: rtl/nx_stream_buffer2.sv
// Two-entry node_message_t FIFO. The head comes straight from the storage
// registers, so the output data has no combinational path from the push side.
// Fullness is purely registered; the caller must not push while full.
module nx_stream_buffer2
    import NXConstants::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  node_message_t i_push_data,
    input  logic          i_pop,
    output node_message_t o_head_data,
    output logic          o_empty,
    output logic          o_full
);

    localparam int DEPTH = 2;

    node_message_t entry_reg [DEPTH];
    logic          wr_ptr_reg;
    logic          wr_ptr_next;
    logic          rd_ptr_reg;
    logic          rd_ptr_next;
    logic [1:0]    count_reg;
    logic [1:0]    count_next;

    // Pointers toggle (wrap modulo 2) on each push/pop; count tracks occupancy 0..2.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (i_push) begin
            wr_ptr_next = ~wr_ptr_reg;
        end
        if (i_pop) begin
            rd_ptr_next = ~rd_ptr_reg;
        end
        case ({i_push, i_pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers; reset empties the buffer immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage: write the slot under the write pointer; cleared on reset so
    // the output data reads zero while the buffer is held in reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (wr_ptr_reg == 1'(i))) begin
                    entry_reg[i] <= i_push_data;
                end
            end
        end
    end

    assign o_head_data = entry_reg[rd_ptr_reg];
    assign o_empty     = (count_reg == 2'd0);
    assign o_full      = (count_reg == 2'd2);

    // Overflow and underflow are unreachable when the caller honours empty/full.
    assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && o_full))
        else $error("nx_stream_buffer2: push while full");
    assert property (@(posedge i_clk) disable iff (i_rst) !(i_pop && o_empty))
        else $error("nx_stream_buffer2: pop while empty");

endmodule

// File: rtl/nx_stream_distributor.sv
// Transmit-side steering for one mesh node: routes each egress message to
// north/east/south/west or local bypass by dimension-ordered decode, with an
// independent 2-entry buffer per output. A full target buffer blocks the
// inbound stream (head-of-line); other outputs keep draining.
module nx_stream_distributor
    import NXConstants::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ID_WIDTH-1:0] i_node_row,
    input  logic [ID_WIDTH-1:0] i_node_column,
    input  node_message_t       i_inbound_data,
    input  logic                i_inbound_valid,
    output logic                o_inbound_ready,
    output node_message_t       o_outbound_data  [DIRECTION_COUNT],
    output logic                o_outbound_valid [DIRECTION_COUNT],
    input  logic                i_outbound_ready [DIRECTION_COUNT],
    output node_message_t       o_bypass_data,
    output logic                o_bypass_valid,
    input  logic                i_bypass_ready
);

    route_t                  inbound_route;
    logic [2:0]              target_index;
    logic                    target_full;

    node_message_t           stream_data [STREAM_COUNT];
    logic [STREAM_COUNT-1:0] stream_empty;
    logic [STREAM_COUNT-1:0] stream_full;
    logic [STREAM_COUNT-1:0] stream_push;
    logic [STREAM_COUNT-1:0] stream_pop;
    logic [STREAM_COUNT-1:0] stream_ready;

    // Decode the target stream and look up its registered fullness. Ready
    // depends only on this decode and buffer state, never on downstream ready.
    always_comb begin
        inbound_route   = nx_route_direction(i_inbound_data.header.row,
                                             i_inbound_data.header.column,
                                             i_node_row, i_node_column);
        target_index    = nx_stream_index(inbound_route);
        target_full     = stream_full[target_index];
        o_inbound_ready = !target_full;
    end

    // One buffer per output stream; push on an accepted inbound message
    // aimed at it, pop on its own downstream handshake.
    generate
        for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_stream
            assign stream_push[gi] = i_inbound_valid && o_inbound_ready
                                     && (target_index == 3'(gi));
            assign stream_pop[gi]  = !stream_empty[gi] && stream_ready[gi];

            nx_stream_buffer2 u_buffer (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_push      (stream_push[gi]),
                .i_push_data (i_inbound_data),
                .i_pop       (stream_pop[gi]),
                .o_head_data (stream_data[gi]),
                .o_empty     (stream_empty[gi]),
                .o_full      (stream_full[gi])
            );
        end
    endgenerate

    // Map the four mesh streams onto the direction-indexed ports.
    generate
        for (genvar gi = 0; gi < DIRECTION_COUNT; gi++) begin : g_direction
            assign o_outbound_data[gi]  = stream_data[gi];
            assign o_outbound_valid[gi] = !stream_empty[gi];
            assign stream_ready[gi]     = i_outbound_ready[gi];
        end
    endgenerate

    assign o_bypass_data              = stream_data[BYPASS_INDEX];
    assign o_bypass_valid             = !stream_empty[BYPASS_INDEX];
    assign stream_ready[BYPASS_INDEX] = i_bypass_ready;

endmodule
